// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: sequences each instruction over a shared ALU
// and one req/ready memory port, with trap, bus-timeout and retire counting.
module multicycle_control #(
    parameter bit          FULL_BRANCH = 1'b1,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op_code,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic             zero,
    input  logic             negative,
    input  logic             overflow,
    input  logic             carry,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_control,
    output logic [1:0]       result_src,
    output logic [2:0]       imm_type,
    output logic             illegal_instr,
    output logic             bus_error,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state
);
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_UPPER, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam bit          TO_EN  = (MEM_TIMEOUT != 0);
    localparam logic [WAIT_W-1:0] WAIT_MAX =
        TO_EN ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

    state_t             r_state;
    logic [WAIT_W-1:0]  r_wait;
    logic               r_illegal;
    logic               r_bus_err;
    logic [CNT_W-1:0]   r_instret;

    logic       w_f3_ok;
    logic       w_f7_ok;
    logic       w_br_ok;
    logic       w_legal;
    logic       w_upper;
    logic       w_sub;
    logic       w_taken;
    logic       w_timeout;
    logic       w_retire;
    logic [2:0] w_alu;

    always_comb begin
        w_f3_ok = (func3 == 3'b000) || (func3 == 3'b111) || (func3 == 3'b110)
               || (func3 == 3'b100) || (func3 == 3'b010);
        w_f7_ok = (func7 == 7'b0000000) || (func7 == 7'b0100000);
        w_br_ok = FULL_BRANCH ? (func3[2:1] != 2'b01) : (func3 == 3'b000);
        w_legal = 1'b0;
        case (op_code)
            OP_LOAD, OP_STORE, OP_JAL, OP_LUI, OP_AUIPC: w_legal = 1'b1;
            OP_R:    w_legal = w_f3_ok && w_f7_ok;
            OP_I:    w_legal = w_f3_ok;
            OP_BR:   w_legal = w_br_ok;
            default: w_legal = 1'b0;
        endcase
        w_upper = (op_code == OP_LUI) || (op_code == OP_AUIPC);
        w_sub   = (op_code == OP_R) && (func7 == 7'b0100000);
        w_alu   = 3'b000;
        unique case (1'b1)
            (func3 == 3'b000): w_alu = w_sub ? 3'b001 : 3'b000;
            (func3 == 3'b111): w_alu = 3'b010;
            (func3 == 3'b110): w_alu = 3'b011;
            (func3 == 3'b100): w_alu = 3'b100;
            (func3 == 3'b010): w_alu = 3'b101;
            default:           w_alu = 3'b000;
        endcase
        w_taken = 1'b0;
        case (func3)
            3'b000:  w_taken = zero;
            3'b001:  w_taken = !zero;
            3'b100:  w_taken = negative ^ overflow;
            3'b101:  w_taken = !(negative ^ overflow);
            3'b110:  w_taken = !carry;
            3'b111:  w_taken = carry;
            default: w_taken = 1'b0;
        endcase
        // ready on the final allowed cycle completes the access
        w_timeout = TO_EN && (r_wait == WAIT_MAX) && !mem_ready;
        w_retire  = (r_state == S_MEMWB) || (r_state == S_ALUWB)
                 || (r_state == S_BRANCH) || (r_state == S_UPPER)
                 || ((r_state == S_MEMWRITE) && mem_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_wait    <= '0;
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
            r_instret <= '0;
        end else begin
            r_wait <= '0;
            if (w_retire) r_instret <= r_instret + CNT_W'(1);
            unique case (r_state)
                S_IDLE: r_state <= S_FETCH;
                S_FETCH, S_MEMREAD, S_MEMWRITE: begin
                    if (mem_ready) begin
                        if (r_state == S_FETCH)        r_state <= S_DECODE;
                        else if (r_state == S_MEMREAD) r_state <= S_MEMWB;
                        else                           r_state <= S_FETCH;
                    end else if (w_timeout) begin
                        r_bus_err <= 1'b1;
                        r_state   <= S_TRAP;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_DECODE: begin
                    if (!w_legal) begin
                        r_illegal <= 1'b1;
                        r_state   <= S_TRAP;
                    end else begin
                        case (op_code)
                            OP_LOAD, OP_STORE: r_state <= S_MEMADR;
                            OP_R:              r_state <= S_EXEC_R;
                            OP_I:              r_state <= S_EXEC_I;
                            OP_BR:             r_state <= S_BRANCH;
                            OP_JAL:            r_state <= S_JAL;
                            default:           r_state <= S_UPPER;
                        endcase
                    end
                end
                S_MEMADR: r_state <= (op_code == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
                S_EXEC_R, S_EXEC_I, S_JAL: r_state <= S_ALUWB;
                S_MEMWB, S_ALUWB, S_BRANCH, S_UPPER: r_state <= S_FETCH;
                S_TRAP: r_state <= S_TRAP;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = 3'b000;
        result_src  = 2'b00;
        imm_type    = 3'b000;
        case (r_state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_type  = w_upper ? 3'b100 : 3'b010;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_type  = (op_code == OP_STORE) ? 3'b001 : 3'b000;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a   = 2'b10;
                alu_control = w_alu;
            end
            S_EXEC_I: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = w_alu;
            end
            S_ALUWB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = 3'b001;
                pc_write    = w_taken;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            S_UPPER: begin
                reg_write  = 1'b1;
                result_src = (op_code == OP_LUI) ? 2'b11 : 2'b00;
            end
            default: ;
        endcase
    end

    assign illegal_instr = r_illegal;
    assign bus_error     = r_bus_err;
    assign instret       = r_instret;
    assign state         = r_state;
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: builds each instruction's expected state walk
// from the ISA rules and checks every cycle's outputs against it.
module tb_multicycle_control;
    localparam int TO = 16;

    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3, S_MEMREAD = 4'd4, S_MEMWB = 4'd5;
    localparam logic [3:0] S_MEMWRITE = 4'd6, S_EXEC_R = 4'd7, S_EXEC_I = 4'd8;
    localparam logic [3:0] S_ALUWB = 4'd9, S_BRANCH = 4'd10, S_JAL = 4'd11;
    localparam logic [3:0] S_UPPER = 4'd12, S_TRAP = 4'd13;

    localparam logic [6:0] OP_LD = 7'b0000011, OP_ST = 7'b0100011;
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011;
    localparam logic [6:0] OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUI = 7'b0010111;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [6:0] op_code = '0;
    logic [2:0] func3 = '0;
    logic [6:0] func7 = '0;
    logic zero = 0, negative = 0, overflow = 0, carry = 0, mem_ready = 0;

    logic mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] alu_control, imm_type;
    logic illegal_instr, bus_error;
    logic [31:0] instret;
    logic [3:0] state;

    logic mem_req2, mem_write2, adr_src2, ir_write2, pc_write2, reg_write2;
    logic [1:0] alu_src_a2, alu_src_b2, result_src2;
    logic [2:0] alu_control2, imm_type2;
    logic illegal_instr2, bus_error2;
    logic [31:0] instret2;
    logic [3:0] state2;

    multicycle_control #(.FULL_BRANCH(1'b1), .MEM_TIMEOUT(TO), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .op_code(op_code), .func3(func3),
        .func7(func7), .zero(zero), .negative(negative), .overflow(overflow),
        .carry(carry), .mem_ready(mem_ready), .mem_req(mem_req),
        .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control),
        .result_src(result_src), .imm_type(imm_type),
        .illegal_instr(illegal_instr), .bus_error(bus_error),
        .instret(instret), .state(state)
    );

    multicycle_control #(.FULL_BRANCH(1'b0), .MEM_TIMEOUT(TO), .CNT_W(32)) dut2 (
        .clk(clk), .rst_n(rst_n), .op_code(op_code), .func3(func3),
        .func7(func7), .zero(zero), .negative(negative), .overflow(overflow),
        .carry(carry), .mem_ready(mem_ready), .mem_req(mem_req2),
        .mem_write(mem_write2), .adr_src(adr_src2), .ir_write(ir_write2),
        .pc_write(pc_write2), .reg_write(reg_write2), .alu_src_a(alu_src_a2),
        .alu_src_b(alu_src_b2), .alu_control(alu_control2),
        .result_src(result_src2), .imm_type(imm_type2),
        .illegal_instr(illegal_instr2), .bus_error(bus_error2),
        .instret(instret2), .state(state2)
    );

    always #5 clk = ~clk;

    logic [17:0] outs;
    assign outs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                   alu_src_a, alu_src_b, alu_control, result_src, imm_type};

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_ret = '0;
    logic [3:0] path_q[$];
    bit rdy_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input bit fb);
        bit f3ok;
        f3ok = (f3 == 0) || (f3 == 7) || (f3 == 6) || (f3 == 4) || (f3 == 2);
        case (op)
            OP_LD, OP_ST, OP_JAL, OP_LUI, OP_AUI: return 1'b1;
            OP_R:    return f3ok && (f7 == 7'h00 || f7 == 7'h20);
            OP_I:    return f3ok;
            OP_BR:   return fb ? !(f3 == 2 || f3 == 3) : (f3 == 0);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input logic [2:0] f3, input bit sub);
        case (f3)
            3'd0:    return sub ? 3'd1 : 3'd0;
            3'd7:    return 3'd2;
            3'd6:    return 3'd3;
            3'd4:    return 3'd4;
            3'd2:    return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [17:0] exp_vec(input logic [3:0] s, input logic [6:0] op,
            input logic [2:0] f3, input logic [6:0] f7, input logic tk, input logic rdy);
        logic mq, mw, ad, iw, pw, rw;
        logic [1:0] a, b, rs;
        logic [2:0] alu, imm;
        {mq, mw, ad, iw, pw, rw} = '0;
        {a, b, rs, alu, imm} = '0;
        case (s)
            S_FETCH:    begin mq = 1; b = 2; rs = 2; iw = rdy; pw = rdy; end
            S_DECODE:   begin a = 1; b = 1; imm = (op == OP_LUI || op == OP_AUI) ? 3'd4 : 3'd2; end
            S_MEMADR:   begin a = 2; b = 1; imm = (op == OP_ST) ? 3'd1 : 3'd0; end
            S_MEMREAD:  begin mq = 1; ad = 1; end
            S_MEMWB:    begin rs = 1; rw = 1; end
            S_MEMWRITE: begin mq = 1; mw = 1; ad = 1; end
            S_EXEC_R:   begin a = 2; alu = alu_of(f3, f7 == 7'h20); end
            S_EXEC_I:   begin a = 2; b = 1; alu = alu_of(f3, 1'b0); end
            S_ALUWB:    rw = 1;
            S_BRANCH:   begin a = 2; alu = 1; pw = tk; end
            S_JAL:      begin a = 1; b = 2; pw = 1; end
            S_UPPER:    begin rw = 1; rs = (op == OP_LUI) ? 2'd3 : 2'd0; end
            default: ;
        endcase
        return {mq, mw, ad, iw, pw, rw, a, b, alu, rs, imm};
    endfunction

    task automatic add(input logic [3:0] s, input bit rdy, input int n);
        for (int i = 0; i < n; i++) begin
            path_q.push_back(s);
            rdy_q.push_back(rdy);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_state", 32'(state), 32'(S_IDLE));
        chk("rst_memreq", 32'(mem_req), 0);
        chk("rst_instret", instret, 0);
        chk("rst_flags", 32'({illegal_instr, bus_error}), 0);
        exp_ret = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outs", 32'(outs), 0);
        chk("idle_state", 32'(state), 32'(S_IDLE));
        @(posedge clk); #1;
    endtask

    // Called one step after the edge that entered FETCH
    task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] ra, input logic [31:0] rb,
                       input int lf, input int lm, input bit hang);
        logic [32:0] d;
        logic tk;
        d = {1'b0, ra} - {1'b0, rb};
        op_code = op; func3 = f3; func7 = f7;
        zero = (ra == rb);
        negative = d[31];
        overflow = (ra[31] != rb[31]) && (d[31] != ra[31]);
        carry = (ra >= rb);
        case (f3)
            3'd0:    tk = (ra == rb);
            3'd1:    tk = (ra != rb);
            3'd4:    tk = ($signed(ra) < $signed(rb));
            3'd5:    tk = ($signed(ra) >= $signed(rb));
            3'd6:    tk = (ra < rb);
            3'd7:    tk = (ra >= rb);
            default: tk = 1'b0;
        endcase
        path_q.delete();
        rdy_q.delete();
        add(S_FETCH, 0, lf);
        add(S_FETCH, 1, 1);
        add(S_DECODE, 1'($urandom), 1);
        if (!legal(op, f3, f7, 1'b1)) add(S_TRAP, 0, 1);
        else case (op)
            OP_LD: begin
                add(S_MEMADR, 1'($urandom), 1);
                add(S_MEMREAD, 0, lm);
                add(S_MEMREAD, 1, 1);
                add(S_MEMWB, 1'($urandom), 1);
            end
            OP_ST: begin
                add(S_MEMADR, 1'($urandom), 1);
                if (hang) begin
                    add(S_MEMWRITE, 0, TO);
                    add(S_TRAP, 0, 1);
                end else begin
                    add(S_MEMWRITE, 0, lm);
                    add(S_MEMWRITE, 1, 1);
                end
            end
            OP_R: begin add(S_EXEC_R, 1'($urandom), 1); add(S_ALUWB, 1'($urandom), 1); end
            OP_I: begin add(S_EXEC_I, 1'($urandom), 1); add(S_ALUWB, 1'($urandom), 1); end
            OP_BR: add(S_BRANCH, 1'($urandom), 1);
            OP_JAL: begin add(S_JAL, 1'($urandom), 1); add(S_ALUWB, 1'($urandom), 1); end
            default: add(S_UPPER, 1'($urandom), 1);
        endcase
        for (int k = 0; k < path_q.size(); k++) begin
            mem_ready = rdy_q[k];
            @(negedge clk);
            chk("state", 32'(state), 32'(path_q[k]));
            chk("outs", 32'(outs), 32'(exp_vec(path_q[k], op, f3, f7, tk, rdy_q[k])));
            chk("flags", 32'({illegal_instr, bus_error}),
                (path_q[k] == S_TRAP) ? (hang ? 32'd1 : 32'd2) : 32'd0);
            if (path_q[k] != S_TRAP) begin @(posedge clk); #1; end
        end
        if (path_q[path_q.size()-1] == S_TRAP) begin
            mem_ready = 1'b1;
            @(posedge clk); #1;
            @(negedge clk);
            chk("trap_hold", 32'(state), 32'(S_TRAP));
            chk("trap_memreq", 32'(mem_req), 0);
            chk("trap_instret", instret, exp_ret);
            do_reset();
        end else begin
            exp_ret = exp_ret + 1;
            chk("instret", instret, exp_ret);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] alu_f3[5];
        logic [2:0] br_f3[6];
        logic [31:0] ra, rb;
        int c;
        alu_f3 = '{3'd0, 3'd7, 3'd6, 3'd4, 3'd2};
        br_f3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        #2;
        do_reset();
        run(OP_R, 3'd0, 7'h00, 1, 2, 0, 0, 0);
        run(OP_LD, 3'd2, 7'h00, 0, 0, 0, 3, 0);
        run(OP_BR, 3'd4, 7'h00, 32'hFFFF_FFF0, 32'd5, 0, 0, 0);
        run(OP_BR, 3'd7, 7'h00, 32'd1, 32'd2, 0, 0, 0);
        run(OP_LUI, 3'd0, 7'h00, 0, 0, 1, 0, 0);
        run(OP_AUI, 3'd0, 7'h00, 0, 0, 0, 0, 0);
        run(OP_JAL, 3'd0, 7'h00, 0, 0, 2, 0, 0);
        run(OP_R, 3'd0, 7'h20, 3, 3, 0, 0, 0);
        run(OP_ST, 3'd2, 7'h00, 0, 0, 0, TO - 1, 0);
        run(OP_LD, 3'd2, 7'h00, 0, 0, 0, TO - 1, 0);
        run(OP_I, 3'd6, 7'h7F, 0, 0, 0, 0, 0);
        run(OP_R, 3'd0, 7'h01, 0, 0, 0, 0, 0);
        run(7'b1110011, 3'd0, 7'h00, 0, 0, 0, 0, 0);
        run(OP_BR, 3'd1, 7'h00, 32'd4, 32'd9, 0, 0, 0);
        chk("fb0_state", 32'(state2), 32'(S_TRAP));
        chk("fb0_illegal", 32'(illegal_instr2), 1);
        run(OP_R, 3'd4, 7'h00, 0, 0, 0, 0, 0);
        run(OP_ST, 3'd2, 7'h00, 0, 0, 0, 0, 1);
        for (int n = 0; n < 60; n++) begin
            c = $urandom_range(0, 7);
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            case (c)
                0: run(OP_LD, 3'($urandom), 7'($urandom), ra, rb, $urandom_range(0, 3), $urandom_range(0, 4), 0);
                1: run(OP_ST, 3'($urandom), 7'($urandom), ra, rb, $urandom_range(0, 3), $urandom_range(0, 4), 0);
                2: run(OP_R, alu_f3[$urandom_range(0, 4)], $urandom_range(0, 1) ? 7'h20 : 7'h00, ra, rb, $urandom_range(0, 3), 0, 0);
                3: run(OP_I, 3'($urandom), 7'($urandom), ra, rb, $urandom_range(0, 3), 0, 0);
                4: run(OP_BR, br_f3[$urandom_range(0, 5)], 7'($urandom), ra, rb, $urandom_range(0, 3), 0, 0);
                5: run(OP_JAL, 3'($urandom), 7'($urandom), ra, rb, $urandom_range(0, 3), 0, 0);
                6: run($urandom_range(0, 1) ? OP_LUI : OP_AUI, 3'($urandom), 7'($urandom), ra, rb, 0, 0, 0);
                default: run(7'($urandom), 3'($urandom), 7'($urandom), ra, rb, 0, 0, 0);
            endcase
        end
        run(OP_R, 3'd7, 7'h00, 0, 0, 0, 0, 0);
        op_code = OP_LD; func3 = 3'd2; func7 = '0;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_state", 32'(state), 32'(S_MEMREAD));
        chk("mid_memreq", 32'({mem_req, adr_src}), 3);
        chk("mid_instret_pre", instret, exp_ret);
        do_reset();
        run(OP_R, 3'd0, 7'h00, 7, 7, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
